load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Datapath-side front end of the word-addressed data memory: accepts byte/half/word load and store
//  requests, drives the memory's address/WriteData/MemRead/MemWrite, and returns extended load data.
//  Sub-word stores are done as read-modify-write, since the memory only writes whole 32-bit words.
//  Sits between the CPU memory stage and the data memory; multi-cycle, one request in flight.
// PARAMETERS
//  ADDR_W     32    byte-address width of req_addr / mem_address
//  MEM_WORDS  1000  memory depth in 32-bit words; used only by the range check under the macro
// PORTS
//  Clk            in   1       clock; all state updates on rising edge
//  Rst            in   1       reset, asynchronous, active-low
//  req_valid      in   1       request present
//  req_ready      out  1       unit can accept; request taken when req_valid & req_ready
//  req_write      in   1       1 = store, 0 = load
//  req_size       in   2       00 byte, 01 half, 10 word, 11 treated as word
//  req_unsigned   in   1       load zero-extends when 1, sign-extends when 0
//  req_addr       in   ADDR_W  byte address
//  req_wdata      in   32      store data, right-justified
//  resp_valid     out  1       one-cycle pulse: request complete
//  resp_rdata     out  32      extended load data (0 for stores), valid with resp_valid
//  resp_err       out  1       misaligned / out-of-range, valid with resp_valid
//  mem_address    out  ADDR_W  word-aligned byte address to memory (low 2 bits always 0)
//  mem_write_data out  32      word to memory
//  mem_read       out  1       memory read strobe
//  mem_write      out  1       memory write strobe; memory writes on Clk rising edge while high
//  mem_read_data  in   32      memory read data, combinational from mem_address
// BEHAVIOUR
//  - Reset (Rst=0, async): state IDLE; req_ready=1 after release; all other outputs 0; captured regs 0.
//  - Request fields are latched at acceptance; inputs are ignored outside IDLE.
//  - FSM states: IDLE, READ, WRITE, RESP. req_ready=1 only in IDLE.
//    IDLE  -> READ  : load, or store of byte/half.
//    IDLE  -> WRITE : word store.
//    READ  -> RESP  : load. In READ: mem_read=1, mem_address=addr & ~3, word captured at end of cycle.
//    READ  -> WRITE : sub-word store; captured word goes to WRITE.
//    WRITE -> RESP  : mem_write=1 for exactly one cycle, mem_write_data = merged/full word.
//    RESP  -> IDLE  : resp_valid=1 one cycle; no backpressure.
//  - Latency (acceptance edge to resp_valid): load 2, word store 2, byte/half store 3 cycles.
//  - Little-endian lanes: byte k = bits[8k+7:8k], k = addr[1:0]; half selected by addr[1].
//  - Load extract: byte/half shifted to bit 0, then sign- or zero-extended to 32 by req_unsigned.
//  - Store merge: replace only the addressed byte/half lane of the captured word with req_wdata low bits.
//  - mem_read and mem_write are never high in the same cycle; both 0 in IDLE and RESP.
//  - Reset mid-operation: async clear drops mem_write before the next edge; no partial write occurs.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or addr>>2 >= MEM_WORDS
//    -> IDLE -> RESP directly, no mem_read/mem_write, resp_err=1, resp_rdata=0.
//  Not defined: no checks; half ignores addr[0], word ignores addr[1:0]; resp_err tied 0.
// STRUCTURE
//  Package lsu_pkg: state enum (IDLE, READ, WRITE, RESP), size codes SZ_BYTE/SZ_HALF/SZ_WORD.
//  Sub-module lsu_lane_align (combinational): extract+extend for loads, lane merge for stores.
//  Top holds FSM, request capture regs, response regs, memory strobes.
// TESTING
//  1 Memory word 0x11223344 at 0x40; load byte 0x41 signed -> resp_rdata 0x00000033, resp_valid 2 cycles after accept.
//  2 Word 0x000080FF at 0x44; load half 0x44 signed -> 0xFFFF80FF; unsigned -> 0x000080FF.
//  3 Word 0xAABBCCDD at 0x48; store byte 0x4A data 0x5E -> one mem_write, word 0xAA5ECCDD, resp 3 cycles.
//  4 Word store 0xDEADBEEF to 0x4C -> no mem_read, one mem_write with 0xDEADBEEF; req_ready low until RESP done.
//  5 With MISALIGN_TRAP_EN: word load at 0x42 -> resp_err=1, rdata 0, no strobes; without: reads word at 0x40.
//  6 Rst low during WRITE of sub-word store -> mem_write drops immediately, target word unchanged, state IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding and request size codes.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } lsu_state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends load data, and merges store data into a word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word_in,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel  = word_in[{addr_lo, 3'b000} +: 8];
      half_sel  = addr_lo[1] ? word_in[31:16] : word_in[15:0];
      load_data = word_in;
      merged    = store_data;
      case (size)
         SZ_BYTE: begin
            load_data = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            merged    = word_in;
            merged[{addr_lo, 3'b000} +: 8] = store_data[7:0];
         end
         SZ_HALF: begin
            load_data = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            merged    = addr_lo[1] ? {store_data[15:0], word_in[15:0]}
                                   : {word_in[31:16], store_data[15:0]};
         end
         default: begin
            load_data = word_in;
            merged    = store_data;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end for a word-only data memory; sub-word stores use read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned or out-of-range requests complete at once with resp_err.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int MEM_WORDS = 1000
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [31:0]       mem_read_data
);

   lsu_state_e        state_q, state_d;
   logic              write_q, write_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;
   logic              req_ready_q, req_ready_d;
   logic              trap;
   logic [31:0]       load_data;
   logic [31:0]       merged;

`ifdef MISALIGN_TRAP_EN
   always_comb begin
      trap = 1'b0;
      case (req_size)
         SZ_BYTE: trap = 1'b0;
         SZ_HALF: trap = req_addr[0];
         default: trap = |req_addr[1:0];
      endcase
      if ((req_addr >> 2) >= ADDR_W'(MEM_WORDS)) trap = 1'b1;
   end
`else
   logic unused_mem_words;
   assign trap             = 1'b0;
   assign unused_mem_words = (MEM_WORDS == 0);
`endif

   lsu_lane_align u_align (
      .size        (size_q),
      .is_unsigned (uns_q),
      .addr_lo     (addr_lo_q),
      .word_in     (mem_read_data),
      .store_data  (wdata_q),
      .load_data   (load_data),
      .merged      (merged)
   );

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      size_d       = size_q;
      uns_d        = uns_q;
      addr_lo_d    = addr_lo_q;
      wdata_d      = wdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      resp_rdata_d = 32'd0;
      resp_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d    = req_write;
               size_d     = req_size;
               uns_d      = req_unsigned;
               addr_lo_d  = req_addr[1:0];
               wdata_d    = req_wdata;
               mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
               if (trap) begin
                  state_d    = RESP;
                  resp_err_d = 1'b1;
               end else if (req_write && req_size[1]) begin
                  state_d     = WRITE;
                  mem_wdata_d = req_wdata;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (write_q) begin
               state_d     = WRITE;
               mem_wdata_d = merged;
            end else begin
               state_d      = RESP;
               resp_rdata_d = load_data;
            end
         end
         WRITE:   state_d = RESP;
         default: state_d = IDLE;
      endcase
      // Strobes are registered copies of the state being entered, so they line up with state_q.
      mem_read_d   = (state_d == READ);
      mem_write_d  = (state_d == WRITE);
      resp_valid_d = (state_d == RESP);
      req_ready_d  = (state_d == IDLE);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         addr_lo_q    <= 2'b00;
         wdata_q      <= 32'd0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'd0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
         req_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         addr_lo_q    <= addr_lo_d;
         wdata_q      <= wdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         req_ready_q  <= req_ready_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign resp_valid     = resp_valid_q;
   assign resp_rdata     = resp_rdata_q;
   assign resp_err       = resp_err_q;
   assign mem_address    = mem_addr_q;
   assign mem_write_data = mem_wdata_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and a table of transactions.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_read_data;

   logic [31:0] mem [0:1023];
   logic        pre_we = 1'b0;
   logic [9:0]  pre_idx = 10'd0;
   logic [31:0] pre_val = 32'd0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32), .MEM_WORDS(1000)) dut (
      .Clk            (clk),
      .Rst            (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_read_data  (mem_read_data)
   );

   assign mem_read_data = mem[mem_address[11:2]];

   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_val;
      else if (mem_write) mem[mem_address[11:2]] <= mem_write_data;
   end

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic [31:0] exp_rdata;
      logic [31:0] exp_word;
      int          exp_lat;
      int          exp_reads;
      int          exp_writes;
      logic        exp_err;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic wr, logic [1:0] sz, logic uns, logic [31:0] addr,
                               logic [31:0] wdata, logic [31:0] init, logic [31:0] exp_rdata,
                               logic [31:0] exp_word, int lat, int rd, int wrc, logic err);
      vec_t v;
      v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata; v.init = init;
      v.exp_rdata = exp_rdata; v.exp_word = exp_word; v.exp_lat = lat;
      v.exp_reads = rd; v.exp_writes = wrc; v.exp_err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] val);
      @(negedge clk);
      pre_we  = 1'b1;
      pre_idx = addr[11:2];
      pre_val = val;
      @(negedge clk);
      pre_we  = 1'b0;
   endtask

   task automatic apply(input int n, input vec_t v);
      int reads, writes, overlap, early, lat;
      logic [31:0] rdata;
      logic err, got;
      preload(v.addr, v.init);
      req_write    = v.wr;
      req_size     = v.sz;
      req_unsigned = v.uns;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      req_valid    = 1'b1;
      chk($sformatf("v%0d ready_before", n), 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFC;
      req_wdata = 32'h0BAD_0BAD;
      reads = 0; writes = 0; overlap = 0; early = 0; lat = 0;
      rdata = 32'd0; err = 1'b0; got = 1'b0;
      for (int c = 1; c <= 10 && !got; c++) begin
         @(negedge clk);
         if (mem_read) reads++;
         if (mem_write) writes++;
         if (mem_read && mem_write) overlap++;
         if (req_ready) early++;
         if (resp_valid) begin
            got = 1'b1; lat = c; rdata = resp_rdata; err = resp_err;
         end
      end
      chk($sformatf("v%0d resp_seen", n), 32'(got), 32'd1);
      chk($sformatf("v%0d latency", n), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d rdata", n), rdata, v.exp_rdata);
      chk($sformatf("v%0d err", n), 32'(err), 32'(v.exp_err));
      chk($sformatf("v%0d mem_reads", n), 32'(reads), 32'(v.exp_reads));
      chk($sformatf("v%0d mem_writes", n), 32'(writes), 32'(v.exp_writes));
      chk($sformatf("v%0d strobe_overlap", n), 32'(overlap), 32'd0);
      chk($sformatf("v%0d ready_busy", n), 32'(early), 32'd0);
      chk($sformatf("v%0d mem_word", n), mem[v.addr[11:2]], v.exp_word);
      @(negedge clk);
      chk($sformatf("v%0d ready_after", n), 32'(req_ready), 32'd1);
      chk($sformatf("v%0d resp_pulse", n), 32'(resp_valid), 32'd0);
      $display("txn %0d: wr=%0d sz=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d word=%h",
               n, v.wr, v.sz, v.uns, v.addr, v.wdata, rdata, err, lat, mem[v.addr[11:2]]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      // Loads: {wr, sz, uns, addr, wdata, init, exp_rdata, exp_word, lat, reads, writes, err}
      vq.push_back(mk(0, 2'b00, 0, 32'h41, 0, 32'h11223344, 32'h00000033, 32'h11223344, 2, 1, 0, 0));
      vq.push_back(mk(0, 2'b01, 0, 32'h44, 0, 32'h000080FF, 32'hFFFF80FF, 32'h000080FF, 2, 1, 0, 0));
      vq.push_back(mk(0, 2'b01, 1, 32'h44, 0, 32'h000080FF, 32'h000080FF, 32'h000080FF, 2, 1, 0, 0));
      vq.push_back(mk(0, 2'b00, 0, 32'h43, 0, 32'h80112233, 32'hFFFFFF80, 32'h80112233, 2, 1, 0, 0));
      vq.push_back(mk(0, 2'b00, 1, 32'h43, 0, 32'h80112233, 32'h00000080, 32'h80112233, 2, 1, 0, 0));
      vq.push_back(mk(0, 2'b01, 1, 32'h56, 0, 32'hCAFE0001, 32'h0000CAFE, 32'hCAFE0001, 2, 1, 0, 0));
      vq.push_back(mk(0, 2'b11, 0, 32'h58, 0, 32'h01020304, 32'h01020304, 32'h01020304, 2, 1, 0, 0));
      vq.push_back(mk(0, 2'b10, 0, 32'hF9C, 0, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 2, 1, 0, 0));
      // Stores
      vq.push_back(mk(1, 2'b00, 0, 32'h4A, 32'h0000005E, 32'hAABBCCDD, 0, 32'hAA5ECCDD, 3, 1, 1, 0));
      vq.push_back(mk(1, 2'b00, 0, 32'h4B, 32'hFFFFFF12, 32'h00000000, 0, 32'h12000000, 3, 1, 1, 0));
      vq.push_back(mk(1, 2'b01, 0, 32'h52, 32'h1234BEEF, 32'h55667788, 0, 32'hBEEF7788, 3, 1, 1, 0));
      vq.push_back(mk(1, 2'b10, 0, 32'h4C, 32'hDEADBEEF, 32'h00000000, 0, 32'hDEADBEEF, 2, 0, 1, 0));
`ifdef MISALIGN_TRAP_EN
      vq.push_back(mk(0, 2'b10, 0, 32'h42, 0, 32'h11223344, 32'h0, 32'h11223344, 1, 0, 0, 1));
      vq.push_back(mk(0, 2'b01, 0, 32'h45, 0, 32'h9ABC7FFF, 32'h0, 32'h9ABC7FFF, 1, 0, 0, 1));
      vq.push_back(mk(1, 2'b10, 0, 32'h4E, 32'h12345678, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1, 0, 0, 1));
      vq.push_back(mk(0, 2'b10, 0, 32'hFA0, 0, 32'h5A5A5A5A, 32'h0, 32'h5A5A5A5A, 1, 0, 0, 1));
`else
      vq.push_back(mk(0, 2'b10, 0, 32'h42, 0, 32'h11223344, 32'h11223344, 32'h11223344, 2, 1, 0, 0));
      vq.push_back(mk(0, 2'b01, 0, 32'h45, 0, 32'h9ABC7FFF, 32'h00007FFF, 32'h9ABC7FFF, 2, 1, 0, 0));
      vq.push_back(mk(1, 2'b10, 0, 32'h4E, 32'h12345678, 32'hFFFFFFFF, 0, 32'h12345678, 2, 0, 1, 0));
      vq.push_back(mk(0, 2'b10, 0, 32'hFA0, 0, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A, 2, 1, 0, 0));
`endif

      repeat (3) @(negedge clk);
      chk("reset_ready_during", 32'(req_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready", 32'(req_ready), 32'd1);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_resp_rdata", resp_rdata, 32'd0);
      chk("reset_resp_err", 32'(resp_err), 32'd0);
      chk("reset_mem_read", 32'(mem_read), 32'd0);
      chk("reset_mem_write", 32'(mem_write), 32'd0);
      chk("reset_mem_address", mem_address, 32'd0);
      chk("reset_mem_wdata", mem_write_data, 32'd0);

      for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

      // Reset asserted while a sub-word store sits in WRITE: the write must never land.
      preload(32'h60, 32'h01020304);
      req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h60; req_wdata = 32'h000000AA; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (mem_write) found = 1'b1;
      end
      chk("rst_mid_write_reached", 32'(found), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mid_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mid_ready", 32'(req_ready), 32'd1);
      chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_word_kept", mem[24], 32'h01020304);
      chk("rst_mid_idle_ready", 32'(req_ready), 32'd1);
      $display("txn reset-mid-write: word=%h ready=%0d", mem[24], req_ready);
      apply(100, mk(0, 2'b00, 1, 32'h60, 0, 32'h01020304, 32'h00000004, 32'h01020304, 2, 1, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
